// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-master external memory port arbiter.
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_ACK    = 2'b10
    } arb_state_e;

    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_BYTE = 2'b10;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the core
// (requester 0) and the loader/debug master (requester 1).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ACCESS_CYCLES = 1,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rq0_req,
    input  logic              rq0_we,
    input  logic [1:0]        rq0_mode,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_ack,
    output logic [DATA_W-1:0] rq0_rdata,
    input  logic              rq1_req,
    input  logic              rq1_we,
    input  logic [1:0]        rq1_mode,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_ack,
    output logic [DATA_W-1:0] rq1_rdata,
    output logic              mem_we,
    output logic [1:0]        mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int               CNT_W    = $clog2(ACCESS_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    typedef struct packed {
        logic              we;
        logic [1:0]        mode;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    arb_state_e        state_q, state_d;
    cmd_t              cmd_q, cmd0, cmd1;
    logic              owner_q, last_grant_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              gnt_vld, gnt_sel;

    assign cmd0 = {rq0_we, rq0_mode, rq0_addr, rq0_wdata};
    assign cmd1 = {rq1_we, rq1_mode, rq1_addr, rq1_wdata};

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        gnt_vld = rq0_req | rq1_req;
        gnt_sel = 1'b0;
        if (rq0_req && rq1_req) gnt_sel = ~last_grant_q;
        else if (rq1_req)       gnt_sel = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (gnt_vld) state_d = ST_ACCESS;
            ST_ACCESS: if (cnt_q == '0) state_d = ST_ACK;
            ST_ACK:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else if (state_q == ST_IDLE && gnt_vld) begin
            cmd_q        <= gnt_sel ? cmd1 : cmd0;
            owner_q      <= gnt_sel;
            last_grant_q <= gnt_sel;
            cnt_q        <= CNT_LOAD;
        end else if (state_q == ST_ACCESS) begin
            // Capture happens on writes too; the owner sees whatever memory returned.
            if (cnt_q == '0) begin
                if (owner_q) rdata1_q <= mem_rdata;
                else         rdata0_q <= mem_rdata;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Write strobe only in the first access cycle (counter still at its load value).
    assign mem_we    = (state_q == ST_ACCESS) && (cnt_q == CNT_LOAD) && cmd_q.we;
    assign mem_mode  = cmd_q.mode;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

    assign rq0_ack   = (state_q == ST_ACK) && !owner_q;
    assign rq1_ack   = (state_q == ST_ACK) &&  owner_q;
    assign rq0_rdata = rdata0_q;
    assign rq1_rdata = rdata1_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (latency 1 and 3), each with a behavioural memory
// and two requester drivers; a negedge monitor pops expected responses on ack.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AC [2] = '{1, 3};

    typedef struct {
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        req   [2][2];
    logic        we    [2][2];
    logic [1:0]  mode  [2][2];
    logic [15:0] addr  [2][2];
    logic [31:0] wdata [2][2];
    logic        ack   [2][2];
    logic [31:0] rdata [2][2];
    logic        m_we    [2];
    logic [1:0]  m_mode  [2];
    logic [15:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rdata [2];

    mem_port_arbiter #(.ACCESS_CYCLES(1)) u_dut (
        .clk(clk), .reset(rst_n[0]),
        .rq0_req(req[0][0]), .rq0_we(we[0][0]), .rq0_mode(mode[0][0]), .rq0_addr(addr[0][0]),
        .rq0_wdata(wdata[0][0]), .rq0_ack(ack[0][0]), .rq0_rdata(rdata[0][0]),
        .rq1_req(req[0][1]), .rq1_we(we[0][1]), .rq1_mode(mode[0][1]), .rq1_addr(addr[0][1]),
        .rq1_wdata(wdata[0][1]), .rq1_ack(ack[0][1]), .rq1_rdata(rdata[0][1]),
        .mem_we(m_we[0]), .mem_mode(m_mode[0]), .mem_addr(m_addr[0]),
        .mem_wdata(m_wdata[0]), .mem_rdata(m_rdata[0])
    );

    mem_port_arbiter #(.ACCESS_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(rst_n[1]),
        .rq0_req(req[1][0]), .rq0_we(we[1][0]), .rq0_mode(mode[1][0]), .rq0_addr(addr[1][0]),
        .rq0_wdata(wdata[1][0]), .rq0_ack(ack[1][0]), .rq0_rdata(rdata[1][0]),
        .rq1_req(req[1][1]), .rq1_we(we[1][1]), .rq1_mode(mode[1][1]), .rq1_addr(addr[1][1]),
        .rq1_wdata(wdata[1][1]), .rq1_ack(ack[1][1]), .rq1_rdata(rdata[1][1]),
        .mem_we(m_we[1]), .mem_mode(m_mode[1]), .mem_addr(m_addr[1]),
        .mem_wdata(m_wdata[1]), .mem_rdata(m_rdata[1])
    );

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [31:0] init_val(input logic [15:0] a);
        if (a == 16'h0010) return 32'hDEADBEEF;
        if (a == 16'h0020) return 32'h11223344;
        return {~a, a};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] md);
        case (md)
            MODE_HALF: return {old[31:16], wd[15:0]};
            MODE_BYTE: return {old[31:8], wd[7:0]};
            default:   return wd;
        endcase
    endfunction

    // Behavioural memory: combinational read, write at the clock edge while mem_we is high.
    bit [31:0] mem    [2][65536];
    bit        mem_ok [2][65536];

    always_comb begin
        for (int d = 0; d < 2; d++)
            m_rdata[d] = mem_ok[d][m_addr[d]] ? mem[d][m_addr[d]] : init_val(m_addr[d]);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++)
            if (m_we[d]) begin
                mem[d][m_addr[d]]    <= merge(m_rdata[d], m_wdata[d], m_mode[d]);
                mem_ok[d][m_addr[d]] <= 1'b1;
            end
    end

    // Reference memory contents as seen by the requesters.
    bit [31:0] ref_mem [2][65536];
    bit        ref_ok  [2][65536];

    function automatic logic [31:0] ref_rd(input int d, input logic [15:0] a);
        return ref_ok[d][a] ? ref_mem[d][a] : init_val(a);
    endfunction

    exp_t        exp_q [2][2][$];
    int          log_r [2][$];
    int          log_c [2][$];
    int          ack_cnt [2][2];
    int          we_cnt  [2];
    logic [1:0]  we_mode [2];
    logic [15:0] we_addr [2];
    logic        prev_we [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            we_cnt[d] = 0;
            prev_we[d] = 1'b0;
            for (int r = 0; r < 2; r++) ack_cnt[d][r] = 0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (m_we[d]) begin
                chk($sformatf("d%0d mem_we single pulse", d), prev_we[d], 1'b0);
                we_cnt[d]  <= we_cnt[d] + 1;
                we_mode[d] <= m_mode[d];
                we_addr[d] <= m_addr[d];
            end
            prev_we[d] <= m_we[d];
            if (ack[d][0] || ack[d][1])
                chk($sformatf("d%0d acks exclusive", d), ack[d][0] & ack[d][1], 1'b0);
            for (int r = 0; r < 2; r++) begin
                if (ack[d][r]) begin
                    exp_t e;
                    ack_cnt[d][r] <= ack_cnt[d][r] + 1;
                    log_r[d].push_back(r);
                    log_c[d].push_back(cyc);
                    chk($sformatf("d%0d rq%0d ack expected", d, r), exp_q[d][r].size() != 0, 1'b1);
                    if (exp_q[d][r].size() != 0) begin
                        e = exp_q[d][r].pop_front();
                        if (e.chk_data)
                            chk($sformatf("d%0d rq%0d rdata", d, r), rdata[d][r], e.data);
                    end
                end
            end
        end
    end

    // Caller is just past a rising edge; req and fields are held until ack, then dropped.
    task automatic xact(input int d, input int r, input bit w, input logic [1:0] md,
                        input logic [15:0] a, input logic [31:0] wd, output int lat);
        exp_t e;
        int   t0;
        bit   got;
        e.chk_data = !w;
        e.data     = ref_rd(d, a);
        if (w) begin
            ref_mem[d][a] = merge(ref_rd(d, a), wd, md);
            ref_ok[d][a]  = 1'b1;
        end
        exp_q[d][r].push_back(e);
        we[d][r] = w; mode[d][r] = md; addr[d][r] = a; wdata[d][r] = wd; req[d][r] = 1'b1;
        t0 = cyc; got = 1'b0; lat = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack[d][r]) begin got = 1'b1; lat = cyc - t0; end
        end
        if (!got) chk($sformatf("d%0d rq%0d ack within budget", d, r), got, 1'b1);
        @(posedge clk); #1;
        req[d][r] = 1'b0;
    endtask

    task automatic rand_run(input int d, input int r, input logic [15:0] base, input int n);
        int lat;
        for (int i = 0; i < n; i++) begin
            int g;
            g = $urandom_range(0, 3);
            if (g > 0) begin repeat (g) @(posedge clk); #1; end
            xact(d, r, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 base + 16'($urandom_range(0, 15)), $urandom, lat);
        end
    endtask

    initial begin
        int lat, lat2, n1;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            for (int r = 0; r < 2; r++) begin
                req[d][r] = 1'b0; we[d][r] = 1'b0; mode[d][r] = MODE_WORD;
                addr[d][r] = '0; wdata[d][r] = '0;
            end
        end
        repeat (2) @(posedge clk); #1;
        chk("reset mem_we", m_we[0], 1'b0);
        chk("reset mem_mode", m_mode[0], 2'b00);
        chk("reset mem_addr", m_addr[0], 16'h0);
        chk("reset mem_wdata", m_wdata[0], 32'h0);
        chk("reset rq0_ack", ack[0][0], 1'b0);
        chk("reset rq1_ack", ack[0][1], 1'b0);
        chk("reset rq0_rdata", rdata[0][0], 32'h0);
        chk("reset rq1_rdata", rdata[0][1], 32'h0);
        @(negedge clk); rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;

        // Single read: address on the port from the grant edge, ack after AC+1 cycles.
        fork
            xact(0, 0, 1'b0, MODE_WORD, 16'h0010, 32'h0, lat);
            begin @(posedge clk); #1; chk("read mem_addr at grant", m_addr[0], 16'h0010); end
        join
        chk("read latency", lat, AC[0] + 1);
        chk("read rq0_rdata held", rdata[0][0], 32'hDEADBEEF);
        chk("read no rq1 ack", ack_cnt[0][1], 0);

        // rq1 byte write followed by rq0 read-back.
        we_cnt[0] = 0;
        xact(0, 1, 1'b1, MODE_BYTE, 16'h0020, 32'h000000A5, lat);
        chk("byte write latency", lat, AC[0] + 1);
        chk("byte write strobe count", we_cnt[0], 1);
        chk("byte write mem_mode", we_mode[0], MODE_BYTE);
        chk("byte write mem_addr", we_addr[0], 16'h0020);
        xact(0, 0, 1'b0, MODE_WORD, 16'h0020, 32'h0, lat);
        chk("byte write readback", rdata[0][0], 32'h112233A5);

        // After reset both requesters held continuously: strict alternation from rq0.
        rst_n[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n[0] = 1'b1;
        @(posedge clk); #1;
        log_r[0].delete(); log_c[0].delete();
        fork
            begin
                xact(0, 0, 1'b0, MODE_WORD, 16'h0010, 32'h0, lat);
                xact(0, 0, 1'b0, MODE_WORD, 16'h0020, 32'h0, lat);
            end
            begin
                xact(0, 1, 1'b0, MODE_WORD, 16'h0020, 32'h0, lat2);
                xact(0, 1, 1'b0, MODE_WORD, 16'h0010, 32'h0, lat2);
            end
        join
        chk("alternate ack count", log_r[0].size(), 4);
        for (int i = 0; i < log_r[0].size(); i++) begin
            chk($sformatf("alternate owner %0d", i), log_r[0][i], i % 2);
            if (i > 0) chk($sformatf("alternate spacing %0d", i), log_c[0][i] - log_c[0][i-1], AC[0] + 2);
        end

        // req held one cycle past ack starts a second access to the same address.
        log_r[0].delete(); log_c[0].delete();
        xact(0, 0, 1'b0, MODE_WORD, 16'h0105, 32'h0, lat);
        xact(0, 0, 1'b0, MODE_WORD, 16'h0105, 32'h0, lat);
        chk("held req ack count", log_r[0].size(), 2);
        if (log_c[0].size() == 2) chk("held req spacing", log_c[0][1] - log_c[0][0], AC[0] + 2);

        // Random contention on disjoint address windows.
        fork
            rand_run(0, 0, 16'h0100, 40);
            rand_run(0, 1, 16'h0200, 40);
        join

        // Latency-3 instance: fields changed after grant must not reach the port.
        fork
            xact(1, 0, 1'b0, MODE_WORD, 16'h0010, 32'h0, lat);
            begin
                @(posedge clk); #2;
                addr[1][0] = 16'h0030;
                for (int i = 0; i < AC[1]; i++) begin
                    @(negedge clk);
                    chk($sformatf("AC3 mem_addr stable %0d", i), m_addr[1], 16'h0010);
                end
            end
        join
        chk("AC3 read latency", lat, AC[1] + 1);

        // Reset in the second access cycle of an rq1 write aborts it.
        @(posedge clk); #1;
        we[1][1] = 1'b1; mode[1][1] = MODE_WORD; addr[1][1] = 16'h0030;
        wdata[1][1] = 32'hCAFEF00D; req[1][1] = 1'b1;
        @(posedge clk); #1;
        chk("abort mem_we first cycle", m_we[1], 1'b1);
        chk("abort mem_wdata first cycle", m_wdata[1], 32'hCAFEF00D);
        @(posedge clk); #2;
        n1 = ack_cnt[1][1];
        rst_n[1] = 1'b0;
        #1;
        chk("abort mem_we", m_we[1], 1'b0);
        chk("abort mem_addr", m_addr[1], 16'h0);
        chk("abort mem_wdata", m_wdata[1], 32'h0);
        chk("abort rq0_rdata", rdata[1][0], 32'h0);
        req[1][1] = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("abort no rq1 ack", ack_cnt[1][1], n1);
        @(negedge clk); rst_n[1] = 1'b1;
        @(posedge clk); #1;
        log_r[1].delete(); log_c[1].delete();
        fork
            xact(1, 0, 1'b0, MODE_WORD, 16'h0010, 32'h0, lat);
            xact(1, 1, 1'b0, MODE_WORD, 16'h0020, 32'h0, lat2);
        join
        chk("post-reset tie ack count", log_r[1].size(), 2);
        if (log_r[1].size() > 0) chk("post-reset tie winner", log_r[1][0], 0);

        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 2; r++)
                chk($sformatf("d%0d rq%0d scoreboard drained", d, r), exp_q[d][r].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
